// File: rtl/mp3_pkg.sv
// Shared constants for the MP3 frame synchroniser and later decode stages:
// FSM state encoding, sync word and header field positions/codes.
package mp3_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_EMIT    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    localparam logic [10:0] SYNC_WORD = 11'h7FF;

    // Header field bit positions within the 32-bit window (MSB = first bit)
    localparam int SYNC_MSB  = 31;
    localparam int SYNC_LSB  = 21;
    localparam int VER_MSB   = 20;
    localparam int VER_LSB   = 19;
    localparam int LAYER_MSB = 18;
    localparam int LAYER_LSB = 17;
    localparam int BR_MSB    = 15;
    localparam int BR_LSB    = 12;
    localparam int SR_MSB    = 11;
    localparam int SR_LSB    = 10;

    // Codes that disqualify (or, for the layer, qualify) a candidate header
    localparam logic [1:0] VER_RESERVED = 2'b01;
    localparam logic [1:0] LAYER_III    = 2'b01;
    localparam logic [3:0] BR_FREE      = 4'b0000;
    localparam logic [3:0] BR_BAD       = 4'b1111;
    localparam logic [1:0] SR_RESERVED  = 2'b11;

    // Number of bits in a full header window
    localparam logic [5:0] FILL_FULL = 6'd32;

endpackage

// File: rtl/mp3_header_check.sv
// Combinational MP3 Layer III header qualifier: flags a 32-bit window that
// carries the sync word and legal version, layer, bitrate and sample-rate codes.
module mp3_header_check
    import mp3_pkg::*;
(
    input  logic [31:0] i_window,
    output logic        o_valid
);

    // Every field rule must hold for the window to count as a header
    always_comb begin
        o_valid = (i_window[SYNC_MSB:SYNC_LSB]   == SYNC_WORD)    &&
                  (i_window[VER_MSB:VER_LSB]     != VER_RESERVED) &&
                  (i_window[LAYER_MSB:LAYER_LSB] == LAYER_III)    &&
                  (i_window[BR_MSB:BR_LSB]       != BR_FREE)      &&
                  (i_window[BR_MSB:BR_LSB]       != BR_BAD)       &&
                  (i_window[SR_MSB:SR_LSB]       != SR_RESERVED);
    end

endmodule

// File: rtl/frame_sync.sv
// MP3 frame synchroniser: pulls bits from an upstream FIFO, hunts for a
// Layer III header in a sliding 32-bit window, hands the header downstream,
// then streams payload bits through a one-entry output slot.
module frame_sync
    import mp3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic        bit_in,
    output logic        bit_rd,
    output logic [31:0] hdr,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic        bit_out,
    output logic        bit_valid,
    input  logic        bit_ready,
    input  logic        resync,
    output logic [15:0] frame_count
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_run;          // set on the first edge after reset release
    logic        r_pend;         // a read was issued last cycle; bit_in is live now
    logic [31:0] r_window;
    logic [5:0]  r_fill;
    logic [31:0] r_hdr;
    logic        r_hdr_valid;
    logic        r_bit_out;
    logic        r_bit_valid;
    logic [15:0] r_frame_count;

    logic        w_hdr_ok;
    logic        w_win_hit;
    logic        w_hs;
    logic        w_rd_want;
    logic        w_bit_rd;

    mp3_header_check u_hdr_chk (
        .i_window (r_window),
        .o_valid  (w_hdr_ok)
    );

    // A full window that qualifies ends the hunt; the handshake moves on to payload
    assign w_win_hit = (r_state == ST_HUNT) && (r_fill == FILL_FULL) && w_hdr_ok;
    assign w_hs      = r_hdr_valid && hdr_ready;

    // Next-state and read-request decode; resync overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_rd_want   = 1'b0;
        case (r_state)
            ST_HUNT: begin
                // No read in the hit cycle so the first payload bit stays in the FIFO
                if (w_win_hit) w_state_nxt = ST_EMIT;
                else           w_rd_want   = 1'b1;
            end
            ST_EMIT: begin
                if (w_hs) w_state_nxt = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                w_rd_want = !r_bit_valid || bit_ready;
            end
            default: w_state_nxt = ST_HUNT;
        endcase
        if (resync) w_state_nxt = ST_HUNT;
        w_bit_rd = w_rd_want && r_run && !fifo_empty && !r_pend && !resync;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_HUNT;
        else      r_state <= w_state_nxt;
    end

    // Window, header, payload slot and frame counter updates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run         <= 1'b0;
            r_pend        <= 1'b0;
            r_window      <= '0;
            r_fill        <= '0;
            r_hdr         <= '0;
            r_hdr_valid   <= 1'b0;
            r_bit_out     <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_run  <= 1'b1;
            r_pend <= w_bit_rd;
            if (resync) begin
                // Abandon the frame; a bit arriving this cycle is simply not captured
                r_window    <= '0;
                r_fill      <= '0;
                r_hdr_valid <= 1'b0;
                r_bit_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        if (r_pend) begin
                            r_window <= {r_window[30:0], bit_in};
                            if (r_fill != FILL_FULL) r_fill <= r_fill + 6'd1;
                        end
                        if (w_win_hit) begin
                            r_hdr       <= r_window;
                            r_hdr_valid <= 1'b1;
                        end
                    end
                    ST_EMIT: begin
                        if (w_hs) begin
                            r_hdr_valid   <= 1'b0;
                            r_frame_count <= r_frame_count + 16'd1;
                        end
                    end
                    ST_PAYLOAD: begin
                        // Reads are only issued into a free slot, so capture never collides
                        if (r_pend) begin
                            r_bit_out   <= bit_in;
                            r_bit_valid <= 1'b1;
                        end else if (r_bit_valid && bit_ready) begin
                            r_bit_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bit_rd      = w_bit_rd;
    assign hdr         = r_hdr;
    assign hdr_valid   = r_hdr_valid;
    assign bit_out     = r_bit_out;
    assign bit_valid   = r_bit_valid;
    assign frame_count = r_frame_count;

endmodule
